// File: rtl/wb_regfile_if.sv
// Bus bundle between the MEM/WB pipeline register, the decode stage and the
// writeback/register-file block. The master drives the writeback and read
// indices; the slave (wb_regfile) returns read data, the selected result and
// the committed-write count.
interface wb_regfile_if #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 32
);
    logic              RegWrite_W;
    logic              MemToReg_W;
    logic [DATA_W-1:0] MemData_W;
    logic [DATA_W-1:0] ALUout_W;
    logic [4:0]        WriteReg_W;
    logic [4:0]        ReadReg1_D;
    logic [4:0]        ReadReg2_D;
    logic [DATA_W-1:0] ReadData1_D;
    logic [DATA_W-1:0] ReadData2_D;
    logic [DATA_W-1:0] Result_W;
    logic [CNT_W-1:0]  RetireCount;

    modport master (
        output RegWrite_W, MemToReg_W, MemData_W, ALUout_W, WriteReg_W,
        output ReadReg1_D, ReadReg2_D,
        input  ReadData1_D, ReadData2_D, Result_W, RetireCount
    );

    modport slave (
        input  RegWrite_W, MemToReg_W, MemData_W, ALUout_W, WriteReg_W,
        input  ReadReg1_D, ReadReg2_D,
        output ReadData1_D, ReadData2_D, Result_W, RetireCount
    );
endinterface

// File: rtl/wb_regfile.sv
// Writeback stage and 32 x DATA_W architectural register file.
// Register 0 has no storage and always reads zero. Both decode read ports see
// the value being committed this cycle through a write-through bypass, so the
// effective read-after-write latency is zero. RetireCount counts committed
// (non-r0, non-reset) register writes and wraps silently.
module wb_regfile #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 32
) (
    input logic          clk,
    input logic          rst,
    wb_regfile_if.slave  bus
);

    logic [DATA_W-1:0] regs_q [1:31];
    logic [CNT_W-1:0]  count_q;
    logic [CNT_W-1:0]  count_d;
    logic [DATA_W-1:0] result;
    logic              commit;

    // Writeback select and the qualified write strobe; reset and r0 never commit.
    always_comb begin
        result = bus.MemToReg_W ? bus.MemData_W : bus.ALUout_W;
        commit = bus.RegWrite_W && (bus.WriteReg_W != 5'd0) && !rst;
    end

    // Register storage r1..r31, each with its own decoded write enable.
    for (genvar g = 1; g < 32; g++) begin : g_reg
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                regs_q[g] <= '0;
            end else if (commit && (bus.WriteReg_W == 5'(g))) begin
                regs_q[g] <= result;
            end
        end
    end

    // Next committed-write count; wraps modulo 2^CNT_W.
    always_comb begin
        count_d = count_q;
        if (commit) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    // Committed-write counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_d_apply: count_q <= count_d;
        end
    end

    // Read port 1: r0 is zero, then bypass of this cycle's commit, then storage.
    always_comb begin
        bus.ReadData1_D = '0;
        if (bus.ReadReg1_D == 5'd0) begin
            bus.ReadData1_D = '0;
        end else if (commit && (bus.WriteReg_W == bus.ReadReg1_D)) begin
            bus.ReadData1_D = result;
        end else begin
            bus.ReadData1_D = regs_q[bus.ReadReg1_D];
        end
    end

    // Read port 2: same priority as port 1, independently indexed.
    always_comb begin
        bus.ReadData2_D = '0;
        if (bus.ReadReg2_D == 5'd0) begin
            bus.ReadData2_D = '0;
        end else if (commit && (bus.WriteReg_W == bus.ReadReg2_D)) begin
            bus.ReadData2_D = result;
        end else begin
            bus.ReadData2_D = regs_q[bus.ReadReg2_D];
        end
    end

    // Result is always presented to the hazard unit, write or not.
    always_comb begin
        bus.Result_W    = result;
        bus.RetireCount = count_q;
    end

endmodule

// File: tb/tb_wb_regfile.sv
// Self-checking bench for wb_regfile. A narrow counter (CNT_W = 4) is used so
// that wrap-around is reachable quickly. The reference model is a plain array
// of 32 words plus a modulo-16 counter updated from the architectural rules.
module tb_wb_regfile;

    localparam int DATA_W = 32;
    localparam int CNT_W  = 4;

    logic clk;
    logic rst;

    wb_regfile_if #(.DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();

    wb_regfile #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Free-running clock, period 10.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Stimulus variables driven onto the bus each step.
    logic        weV;
    logic        mtrV;
    logic [31:0] mdV;
    logic [31:0] aluV;
    logic [4:0]  wrV;
    logic [4:0]  r1V;
    logic [4:0]  r2V;
    logic        rstV;

    // Reference model.
    logic [31:0] mref [0:31];
    int unsigned mcnt;

    int checks;
    int errors;

    function automatic logic [31:0] mResult();
        return mtrV ? mdV : aluV;
    endfunction

    function automatic logic mCommit();
        return weV && (wrV != 5'd0) && !rstV;
    endfunction

    function automatic logic [31:0] expRead(input logic [4:0] idx);
        if (idx == 5'd0) return 32'd0;
        if (mCommit() && (wrV == idx)) return mResult();
        return mref[idx];
    endfunction

    task automatic modelReset();
        for (int i = 0; i < 32; i++) mref[i] = 32'd0;
        mcnt = 0;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus();
        bus.RegWrite_W = weV;
        bus.MemToReg_W = mtrV;
        bus.MemData_W  = mdV;
        bus.ALUout_W   = aluV;
        bus.WriteReg_W = wrV;
        bus.ReadReg1_D = r1V;
        bus.ReadReg2_D = r2V;
        rst            = rstV;
    endtask

    // One step starting at a negedge: drive, check combinational outputs
    // before the rising edge, clock, then check the counter after the edge.
    task automatic step(input string tag);
        if (rstV) modelReset();
        applyStimulus();
        #1;
        checkOutput({tag, "/result"}, bus.Result_W, mResult());
        checkOutput({tag, "/rd1"}, bus.ReadData1_D, expRead(r1V));
        checkOutput({tag, "/rd2"}, bus.ReadData2_D, expRead(r2V));
        checkOutput({tag, "/cntPre"}, 32'(bus.RetireCount), 32'(mcnt));
        @(posedge clk);
        if (mCommit()) begin
            mref[wrV] = mResult();
            mcnt = (mcnt + 1) % 16;
        end
        #1;
        checkOutput({tag, "/cnt"}, 32'(bus.RetireCount), 32'(mcnt));
        @(negedge clk);
        rstV = 1'b0;
    endtask

    task automatic setW(input logic we, input logic mtr, input logic [31:0] md,
                        input logic [31:0] alu, input logic [4:0] wr,
                        input logic [4:0] r1, input logic [4:0] r2);
        weV = we; mtrV = mtr; mdV = md; aluV = alu; wrV = wr; r1V = r1; r2V = r2;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        modelReset();
        setW(1'b0, 1'b0, 32'd0, 32'd0, 5'd0, 5'd0, 5'd0);
        rstV = 1'b1;
        applyStimulus();
        #12;
        checkOutput("resetCnt", 32'(bus.RetireCount), 32'd0);
        bus.ReadReg1_D = 5'd7;
        bus.ReadReg2_D = 5'd31;
        #1;
        checkOutput("resetRd1", bus.ReadData1_D, 32'd0);
        checkOutput("resetRd2", bus.ReadData2_D, 32'd0);
        @(negedge clk);
        rstV = 1'b0;

        // Preload r1..r31 with nonzero values.
        for (int i = 1; i < 32; i++) begin
            setW(1'b1, 1'(i % 2), $urandom | 32'h1, $urandom | 32'h1, 5'(i),
                 5'($urandom_range(0, 31)), 5'(i));
            step("preload");
        end

        // Reset asserted between edges with a write pending: write is lost.
        setW(1'b1, 1'b0, 32'h0, 32'hDEAD_BEEF, 5'd9, 5'd9, 5'd17);
        rstV = 1'b1;
        step("midReset");
        setW(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd9, 5'd1);
        step("afterReset");
        setW(1'b1, 1'b0, 32'h0, 32'h1234, 5'd5, 5'd5, 5'd0);
        step("writeR5");
        setW(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd5, 5'd5);
        step("readR5");
        checkOutput("r5Value", bus.ReadData1_D, 32'h1234);
        checkOutput("r5Count", 32'(bus.RetireCount), 32'd1);

        // Writeback select.
        setW(1'b1, 1'b0, 32'h0000_BBBB, 32'hAAAA_0000, 5'd8, 5'd8, 5'd0);
        step("selAlu");
        setW(1'b1, 1'b1, 32'h0000_BBBB, 32'hAAAA_0000, 5'd8, 5'd8, 5'd0);
        step("selMem");
        setW(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd8, 5'd8);
        step("readR8");
        checkOutput("r8Value", bus.ReadData2_D, 32'h0000_BBBB);

        // Bypass: without and with the write present.
        setW(1'b1, 1'b0, 32'h0, 32'h11, 5'd3, 5'd0, 5'd0);
        step("writeR3");
        setW(1'b0, 1'b0, 32'h0, 32'h22, 5'd3, 5'd3, 5'd3);
        step("noBypass");
        setW(1'b1, 1'b0, 32'h0, 32'h22, 5'd3, 5'd3, 5'd3);
        step("bypass");

        // Writes to r0 are discarded, never bypassed, never counted.
        for (int i = 0; i < 3; i++) begin
            setW(1'b1, 1'b0, 32'h0, 32'hFFFF_FFFF, 5'd0, 5'd0, 5'd0);
            step("r0Write");
        end

        // Counter wrap with interleaved idle cycles.
        for (int i = 0; i < 20; i++) begin
            setW(1'(i % 3 != 2), 1'b0, 32'h0, 32'(i), 5'(1 + i % 31), 5'd1, 5'd2);
            step("wrap");
        end

        // Random soak with occasional reset pulses coincident with writes.
        for (int i = 0; i < 10000; i++) begin
            setW(1'($urandom_range(0, 3) != 0), 1'($urandom), $urandom, $urandom,
                 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                 5'($urandom_range(0, 31)));
            if ($urandom_range(0, 3) == 0) r1V = wrV;
            if ($urandom_range(0, 3) == 0) r2V = wrV;
            rstV = ($urandom_range(0, 49) == 0);
            step("soak");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
